// File: rtl/chimera_wide_bypass_sequencer.sv
// chimera_wide_bypass_sequencer
//
// Purpose: turns an asynchronous-to-traffic bypass request into a glitch-free
// bypass_mode_o for the cluster adapter's wide-port demux. Outstanding wide
// writes (AW -> B) and reads (AR -> R last) are counted. The AW/AR address gate
// is closed before the mode flips, and all outstanding traffic is drained
// first. An address valid that is already presented downstream is never
// withdrawn before its handshake.
//
// Ports:
//   clk_i                       SoC clock
//   rst_i                       synchronous active-high reset
//   bypass_req_i                requested mode (1 = route wide traffic narrow)
//   bypass_mode_o               applied mode (registered)
//   switching_o                 high while a mode change is in progress (registered)
//   error_o                     sticky counter-underflow flag (registered)
//   slv_aw_valid_i/_ready_o     upstream AW handshake
//   mst_aw_valid_o/_ready_i     downstream AW handshake
//   slv_ar_valid_i/_ready_o     upstream AR handshake
//   mst_ar_valid_o/_ready_i     downstream AR handshake
//   b_valid_i, b_ready_i        observed B handshake
//   r_valid_i, r_ready_i, r_last_i  observed R handshake
//   wr_outstanding_o            outstanding write count (registered)
//   rd_outstanding_o            outstanding read count (registered)
module chimera_wide_bypass_sequencer #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                bypass_req_i,
  output logic                bypass_mode_o,
  output logic                switching_o,
  output logic                error_o,
  input  logic                slv_aw_valid_i,
  output logic                slv_aw_ready_o,
  output logic                mst_aw_valid_o,
  input  logic                mst_aw_ready_i,
  input  logic                slv_ar_valid_i,
  output logic                slv_ar_ready_o,
  output logic                mst_ar_valid_o,
  input  logic                mst_ar_ready_i,
  input  logic                b_valid_i,
  input  logic                b_ready_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o
);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] CNT_MAX  = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CNT_ZERO = CntWidth'(0);

  state_e              state_r;
  logic                target_r;
  logic                mode_r;
  logic                switching_r;
  logic                err_r;
  logic [CntWidth-1:0] wr_cnt_r;
  logic [CntWidth-1:0] rd_cnt_r;
  logic                aw_pend_r;
  logic                ar_pend_r;

  logic                aw_open_s;
  logic                ar_open_s;
  logic                wr_inc_s;
  logic                wr_dec_s;
  logic                rd_inc_s;
  logic                rd_dec_s;
  logic [CntWidth:0]   wr_step_s;
  logic [CntWidth:0]   rd_step_s;

  // Counter update: returns {underflow, next_value}. An unmatched decrement at
  // zero holds zero and reports underflow; increment and decrement together cancel.
  function automatic logic [CntWidth:0] cnt_step(input logic [CntWidth-1:0] cnt,
                                                 input logic inc,
                                                 input logic dec);
    logic [CntWidth:0] res;
    case ({inc, dec})
      2'b10: res = {1'b0, cnt + CNT_ONE};
      2'b01: begin
        if (cnt == CNT_ZERO) begin
          res = {1'b1, CNT_ZERO};
        end else begin
          res = {1'b0, cnt - CNT_ONE};
        end
      end
      default: res = {1'b0, cnt};
    endcase
    return res;
  endfunction

  // Address gate: open while STABLE, or while a presented valid awaits its
  // handshake. The cap check cannot drop a pending valid because a counter only
  // rises on its own channel's handshake.
  always_comb begin
    aw_open_s      = (state_r == ST_STABLE) | aw_pend_r;
    ar_open_s      = (state_r == ST_STABLE) | ar_pend_r;
    mst_aw_valid_o = slv_aw_valid_i & aw_open_s & (wr_cnt_r < CNT_MAX);
    slv_aw_ready_o = mst_aw_ready_i & aw_open_s & (wr_cnt_r < CNT_MAX);
    mst_ar_valid_o = slv_ar_valid_i & ar_open_s & (rd_cnt_r < CNT_MAX);
    slv_ar_ready_o = mst_ar_ready_i & ar_open_s & (rd_cnt_r < CNT_MAX);
  end

  // Handshake decode and next counter values.
  always_comb begin
    wr_inc_s  = mst_aw_valid_o & mst_aw_ready_i;
    wr_dec_s  = b_valid_i & b_ready_i;
    rd_inc_s  = mst_ar_valid_o & mst_ar_ready_i;
    rd_dec_s  = r_valid_i & r_ready_i & r_last_i;
    wr_step_s = cnt_step(wr_cnt_r, wr_inc_s, wr_dec_s);
    rd_step_s = cnt_step(rd_cnt_r, rd_inc_s, rd_dec_s);
  end

  // Outstanding counters, pending-valid flags and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_r  <= CNT_ZERO;
      rd_cnt_r  <= CNT_ZERO;
      aw_pend_r <= 1'b0;
      ar_pend_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      wr_cnt_r  <= wr_step_s[CntWidth-1:0];
      rd_cnt_r  <= rd_step_s[CntWidth-1:0];
      aw_pend_r <= mst_aw_valid_o & ~mst_aw_ready_i;
      ar_pend_r <= mst_ar_valid_o & ~mst_ar_ready_i;
      err_r     <= err_r | wr_step_s[CntWidth] | rd_step_s[CntWidth];
    end
  end

  // Mode sequencer: STABLE -> DRAIN on request mismatch, DRAIN -> SWITCH once
  // nothing is outstanding or pending, SWITCH applies the latched target.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_STABLE;
      target_r    <= 1'b0;
      mode_r      <= 1'b0;
      switching_r <= 1'b0;
    end else begin
      case (state_r)
        ST_STABLE: begin
          if (bypass_req_i != mode_r) begin
            target_r    <= bypass_req_i;
            state_r     <= ST_DRAIN;
            switching_r <= 1'b1;
          end else begin
            state_r     <= ST_STABLE;
            switching_r <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if ((wr_cnt_r == CNT_ZERO) && (rd_cnt_r == CNT_ZERO) &&
              !aw_pend_r && !ar_pend_r) begin
            state_r <= ST_SWITCH;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_SWITCH: begin
          mode_r      <= target_r;
          state_r     <= ST_STABLE;
          switching_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_STABLE;
          switching_r <= 1'b0;
        end
      endcase
    end
  end

  assign bypass_mode_o    = mode_r;
  assign switching_o      = switching_r;
  assign error_o          = err_r;
  assign wr_outstanding_o = wr_cnt_r;
  assign rd_outstanding_o = rd_cnt_r;

endmodule

// File: tb/tb_chimera_wide_bypass_sequencer.sv
// Testbench for chimera_wide_bypass_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_chimera_wide_bypass_sequencer;

  localparam int MAXO = 8;

  logic       clk = 1'b0;
  logic       rst, req;
  logic       saw_v, maw_r, sar_v, mar_r;
  logic       bv, br, rv, rr, rl;
  logic       mode, sw, err;
  logic       saw_r, maw_v, sar_r, mar_v;
  logic [3:0] wr_o, rd_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: applied mode, a phase (0 idle, 1 draining, 2 committing),
  // outstanding totals and whether an address is parked downstream.
  int m_mode, m_target, m_phase, m_err, m_wr, m_rd, m_awp, m_arp;

  always #5 clk = ~clk;

  chimera_wide_bypass_sequencer #(.MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .bypass_req_i(req),
    .bypass_mode_o(mode), .switching_o(sw), .error_o(err),
    .slv_aw_valid_i(saw_v), .slv_aw_ready_o(saw_r),
    .mst_aw_valid_o(maw_v), .mst_aw_ready_i(maw_r),
    .slv_ar_valid_i(sar_v), .slv_ar_ready_o(sar_r),
    .mst_ar_valid_o(mar_v), .mst_ar_ready_i(mar_r),
    .b_valid_i(bv), .b_ready_i(br),
    .r_valid_i(rv), .r_ready_i(rr), .r_last_i(rl),
    .wr_outstanding_o(wr_o), .rd_outstanding_o(rd_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_target = 0; m_phase = 0; m_err = 0;
    m_wr = 0; m_rd = 0; m_awp = 0; m_arp = 0;
  endtask

  // One clock: compare every output mid-cycle, then advance the model with
  // the inputs the DUT sampled at the edge. Returns 1 ns after the edge.
  task automatic tick();
    int e_awv, e_awr, e_arv, e_arr, open_aw, open_ar;
    int aw_hs, ar_hs, b_hs, r_hs, n_wr, n_rd;
    #4;
    open_aw = (m_phase == 0 || m_awp != 0) ? 1 : 0;
    open_ar = (m_phase == 0 || m_arp != 0) ? 1 : 0;
    e_awv = (saw_v && open_aw && m_wr < MAXO) ? 1 : 0;
    e_awr = (maw_r && open_aw && m_wr < MAXO) ? 1 : 0;
    e_arv = (sar_v && open_ar && m_rd < MAXO) ? 1 : 0;
    e_arr = (mar_r && open_ar && m_rd < MAXO) ? 1 : 0;
    chk("mode", mode, m_mode);
    chk("switching", sw, (m_phase != 0) ? 1 : 0);
    chk("error", err, m_err);
    chk("wr_cnt", wr_o, m_wr);
    chk("rd_cnt", rd_o, m_rd);
    chk("mst_aw_valid", maw_v, e_awv);
    chk("slv_aw_ready", saw_r, e_awr);
    chk("mst_ar_valid", mar_v, e_arv);
    chk("slv_ar_ready", sar_r, e_arr);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      aw_hs = (e_awv && maw_r) ? 1 : 0;
      ar_hs = (e_arv && mar_r) ? 1 : 0;
      b_hs  = (bv && br) ? 1 : 0;
      r_hs  = (rv && rr && rl) ? 1 : 0;
      n_wr = m_wr + aw_hs - b_hs;
      if (n_wr < 0) begin n_wr = 0; m_err = 1; end
      n_rd = m_rd + ar_hs - r_hs;
      if (n_rd < 0) begin n_rd = 0; m_err = 1; end
      if (m_phase == 0) begin
        if (int'(req) != m_mode) begin m_target = int'(req); m_phase = 1; end
      end else if (m_phase == 1) begin
        if (m_wr == 0 && m_rd == 0 && m_awp == 0 && m_arp == 0) m_phase = 2;
      end else begin
        m_mode = m_target; m_phase = 0;
      end
      m_wr = n_wr; m_rd = n_rd;
      m_awp = (e_awv && !maw_r) ? 1 : 0;
      m_arp = (e_arv && !mar_r) ? 1 : 0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0;
    saw_v = 1'b0; maw_r = 1'b0; sar_v = 1'b0; mar_r = 1'b0;
    bv = 1'b0; br = 1'b0; rv = 1'b0; rr = 1'b0; rl = 1'b0;
    model_reset();

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mode", mode, 0); chk("rst_sw", sw, 0); chk("rst_err", err, 0);
    chk("rst_wr", wr_o, 0); chk("rst_rd", rd_o, 0);
    saw_v = 1'b1; #1;
    chk("rst_aw_follow1", maw_v, 1);
    saw_v = 1'b0; #1;
    chk("rst_aw_follow0", maw_v, 0);
    tick();

    // Idle switch up and back down
    req = 1'b1; tick();
    chk("idle_up_sw1", sw, 1); chk("idle_up_mode1", mode, 0);
    tick(); chk("idle_up_sw2", sw, 1); chk("idle_up_mode2", mode, 0);
    tick(); chk("idle_up_sw3", sw, 0); chk("idle_up_mode3", mode, 1);
    req = 1'b0; tick();
    chk("idle_dn_sw1", sw, 1);
    tick(); chk("idle_dn_sw2", sw, 1); chk("idle_dn_mode2", mode, 1);
    tick(); chk("idle_dn_sw3", sw, 0); chk("idle_dn_mode3", mode, 0);

    // Drain with outstanding traffic
    saw_v = 1'b1; maw_r = 1'b1; repeat (3) tick();
    saw_v = 1'b0; maw_r = 1'b0;
    chk("drain_wr3", wr_o, 3);
    sar_v = 1'b1; mar_r = 1'b1; repeat (2) tick();
    sar_v = 1'b0; mar_r = 1'b0;
    chk("drain_rd2", rd_o, 2);
    req = 1'b1; tick();
    saw_v = 1'b1; maw_r = 1'b1; sar_v = 1'b1; mar_r = 1'b1; #1;
    chk("drain_aw_closed", maw_v, 0); chk("drain_aw_rdy_closed", saw_r, 0);
    chk("drain_ar_closed", mar_v, 0);
    bv = 1'b1; br = 1'b1;
    repeat (3) begin tick(); chk("drain_no_aw", maw_v, 0); end
    bv = 1'b0; br = 1'b0;
    chk("drain_wr0", wr_o, 0);
    rv = 1'b1; rr = 1'b1; rl = 1'b0; tick(); chk("r_beat_nodec", rd_o, 2);
    rl = 1'b1; tick(); chk("r_last_dec", rd_o, 1);
    rl = 1'b0; tick(); chk("r_beat_nodec2", rd_o, 1);
    rl = 1'b1; tick();
    rv = 1'b0; rr = 1'b0; rl = 1'b0;
    saw_v = 1'b0; maw_r = 1'b0; sar_v = 1'b0; mar_r = 1'b0;
    chk("drain_rd0", rd_o, 0); chk("drain_mode_a", mode, 0);
    tick(); chk("drain_mode_b", mode, 0); chk("drain_sw_b", sw, 1);
    tick(); chk("drain_mode_c", mode, 1); chk("drain_sw_c", sw, 0);

    // Pending valid survives the gate closing
    saw_v = 1'b1; maw_r = 1'b0; tick();
    req = 1'b0; tick();
    chk("pend_hold1", maw_v, 1); chk("pend_sw", sw, 1);
    tick(); chk("pend_hold2", maw_v, 1);
    maw_r = 1'b1; tick();
    saw_v = 1'b0; maw_r = 1'b0;
    chk("pend_wr1", wr_o, 1);
    tick(); tick();
    chk("pend_wait_b_sw", sw, 1); chk("pend_wait_b_mode", mode, 1);
    bv = 1'b1; br = 1'b1; tick();
    bv = 1'b0; br = 1'b0;
    chk("pend_wr0", wr_o, 0);
    tick(); chk("pend_mode_b", mode, 1);
    tick(); chk("pend_mode_c", mode, 0);

    // Outstanding cap on AR
    sar_v = 1'b1; mar_r = 1'b1; repeat (8) tick();
    chk("cap_rd8", rd_o, 8); chk("cap_arv", mar_v, 0); chk("cap_arr", sar_r, 0);
    tick(); chk("cap_rd8_hold", rd_o, 8);
    rv = 1'b1; rr = 1'b1; rl = 1'b1; tick();
    rv = 1'b0; rr = 1'b0; rl = 1'b0;
    chk("cap_rd7", rd_o, 7); chk("cap_reopen_v", mar_v, 1); chk("cap_reopen_r", sar_r, 1);
    tick(); chk("cap_rd8_again", rd_o, 8);
    sar_v = 1'b0; mar_r = 1'b0;
    rv = 1'b1; rr = 1'b1; rl = 1'b1; repeat (8) tick();
    rv = 1'b0; rr = 1'b0; rl = 1'b0;
    chk("cap_drained", rd_o, 0);

    // Underflow is sticky
    bv = 1'b1; br = 1'b1; tick();
    bv = 1'b0; br = 1'b0;
    chk("uf_err", err, 1); chk("uf_wr0", wr_o, 0);
    tick(); tick(); chk("uf_sticky", err, 1);

    // Reset during DRAIN loses the pending change
    saw_v = 1'b1; maw_r = 1'b1; tick();
    saw_v = 1'b0; maw_r = 1'b0;
    req = 1'b1; tick(); tick();
    chk("mrst_in_drain", sw, 1);
    rst = 1'b1; req = 1'b0; tick();
    rst = 1'b0;
    chk("mrst_sw", sw, 0); chk("mrst_mode", mode, 0);
    chk("mrst_err", err, 0); chk("mrst_wr", wr_o, 0);
    tick(); chk("mrst_stays", sw, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) req = ~req;
      saw_v = 1'($urandom_range(0, 1)); maw_r = 1'($urandom_range(0, 1));
      sar_v = 1'($urandom_range(0, 1)); mar_r = 1'($urandom_range(0, 1));
      bv = 1'($urandom_range(0, 2) == 0); br = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 2) == 0);
      rst = 1'($urandom_range(0, 199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
